// File: rtl/colisor_pkg.sv
// rtl/colisor_pkg.sv - shared states, default widths and player encoding for the shot collider
package colisor_pkg;

  localparam int DATA_W_DEF   = 64;
  localparam int ADDR_W_DEF   = 5;
  localparam int COL_W_DEF    = 6;
  localparam int ROWS_DEF     = 11;
  localparam int READ_LAT_DEF = 2;

  localparam int ACERTOS_W    = 7;

  localparam logic JOGADOR_UM   = 1'b0;
  localparam logic JOGADOR_DOIS = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } estado_t;

endpackage

// File: rtl/contador_acertos.sv
// rtl/contador_acertos.sv - saturating hit counter, one per board
module contador_acertos
  import colisor_pkg::*;
#(
  parameter int W = ACERTOS_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on each landed hit, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/colisor_tiro.sv
// rtl/colisor_tiro.sv - shot resolver: read board row, test cell, clear it on hit (optional hit counters: COLISOR_CONTADOR_ACERTOS_EN)
module colisor_tiro
  import colisor_pkg::*;
#(
  parameter int ROWS     = ROWS_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int COL_W    = COL_W_DEF,
  parameter int READ_LAT = READ_LAT_DEF
) (
  input  logic              clk,
  input  logic              resetGeral,
  input  logic              shot_valid,
  output logic              shot_ready,
  input  logic [ADDR_W-1:0] shot_row,
  input  logic [COL_W-1:0]  shot_col,
  input  logic              shot_player,
  output logic              readyColisor,
  output logic              jogadorColisor,
  output logic [ADDR_W-1:0] colisor_addr,
  output logic [DATA_W-1:0] colisor_data,
  output logic              colisor_wrep1,
  output logic              colisor_wrep2,
  input  logic [DATA_W-1:0] dataReadColisor,
  output logic              result_valid,
  output logic              result_hit,
  output logic              result_invalid
`ifdef COLISOR_CONTADOR_ACERTOS_EN
  ,
  output logic [ACERTOS_W-1:0] acertos_p1,
  output logic [ACERTOS_W-1:0] acertos_p2
`endif
);

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT - 1);

  estado_t             state, state_n;
  logic [ADDR_W-1:0]   row_q;
  logic [COL_W-1:0]    col_q;
  logic                player_q;
  logic                invalid_q;
  logic                hit_q;
  logic [DATA_W-1:0]   data_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                accept;
  logic                row_out;
  logic                bus_own;

  assign accept  = (state == IDLE) && shot_valid;
  assign row_out = (32'(shot_row) >= ROWS);

  // State register; reset drops straight back to IDLE, cancelling any write.
  always_ff @(posedge clk or negedge resetGeral) begin
    if (!resetGeral) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state: bad rows skip the bus entirely, valid rows walk the full read/write sequence.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (shot_valid) state_n = row_out ? DONE : REQ;
      REQ:     state_n = WAIT;
      WAIT:    if (cnt_q == '0) state_n = CHECK;
      CHECK:   state_n = WRITE;
      WRITE:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Shot latch, read-latency countdown and hit/write-back row capture.
  always_ff @(posedge clk or negedge resetGeral) begin
    if (!resetGeral) begin
      row_q     <= '0;
      col_q     <= '0;
      player_q  <= 1'b0;
      invalid_q <= 1'b0;
      hit_q     <= 1'b0;
      data_q    <= '0;
      cnt_q     <= '0;
    end else begin
      if (accept) begin
        row_q     <= shot_row;
        col_q     <= shot_col;
        player_q  <= shot_player;
        invalid_q <= row_out;
        hit_q     <= 1'b0;
      end
      if (state == REQ) begin
        cnt_q <= CNT_LOAD;
      end else if ((state == WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (state == CHECK) begin
        hit_q  <= dataReadColisor[col_q];
        data_q <= dataReadColisor & ~(DATA_W'(1) << col_q);
      end
    end
  end

  // Bus is owned only from REQ to WRITE so the controller is free between shots.
  assign bus_own        = (state == REQ) || (state == WAIT) ||
                          (state == CHECK) || (state == WRITE);
  assign shot_ready     = (state == IDLE);
  assign readyColisor   = bus_own;
  assign jogadorColisor = bus_own & player_q;
  assign colisor_addr   = bus_own ? row_q : '0;
  assign colisor_data   = bus_own ? data_q : '0;
  assign colisor_wrep1  = (state == WRITE) && hit_q && (player_q == JOGADOR_UM);
  assign colisor_wrep2  = (state == WRITE) && hit_q && (player_q == JOGADOR_DOIS);
  assign result_valid   = (state == DONE);
  assign result_hit     = (state == DONE) && hit_q;
  assign result_invalid = (state == DONE) && invalid_q;

`ifdef COLISOR_CONTADOR_ACERTOS_EN
  logic inc_p1, inc_p2;

  assign inc_p1 = (state == DONE) && hit_q && (player_q == JOGADOR_UM);
  assign inc_p2 = (state == DONE) && hit_q && (player_q == JOGADOR_DOIS);

  contador_acertos #(.W(ACERTOS_W)) u_acertos_p1 (
    .clk   (clk),
    .rst_n (resetGeral),
    .inc   (inc_p1),
    .count (acertos_p1)
  );

  contador_acertos #(.W(ACERTOS_W)) u_acertos_p2 (
    .clk   (clk),
    .rst_n (resetGeral),
    .inc   (inc_p2),
    .count (acertos_p2)
  );
`endif

endmodule

// File: doc/colisor_tiro.md
Name: colisor_tiro

Overview:
- Shot-resolution stage directly upstream of the memory controller (ControladoMemoria), driving its colisor port group.
- Accepts one shot (target player, row, column), reads that board row through the controller and tests the cell bit.
- On a hit, writes the row back with the bit cleared and reports hit/miss to the game FSM.
- Consumers of its result: game control and scoring.

Parameters:
- ROWS, 11: valid board rows, 0..ROWS-1.
- DATA_W, 64: bits per board row, one bit per cell.
- ADDR_W, 5: row address width.
- COL_W, 6: column index width, log2(DATA_W).
- READ_LAT, 2: cycles from address presentation to valid dataReadColisor; must be at least 1.

Ports:
- clk  in  1  system clock.
- resetGeral  in  1  asynchronous reset, active-low.
- shot_valid  in  1  shot request.
- shot_ready  out  1  block idle, can accept a shot.
- shot_row  in  ADDR_W  target row.
- shot_col  in  COL_W  target column; selects data bit shot_col, LSB is column 0.
- shot_player  in  1  board attacked: 0 = player 1 memory, 1 = player 2 memory.
- readyColisor  out  1  colisor owns the controller bus.
- jogadorColisor  out  1  memory select to the controller.
- colisor_addr  out  ADDR_W  row address to the controller.
- colisor_data  out  DATA_W  write-back row.
- colisor_wrep1  out  1  write enable, player 1 memory.
- colisor_wrep2  out  1  write enable, player 2 memory.
- dataReadColisor  in  DATA_W  row read back via the controller.
- result_valid  out  1  one-cycle result pulse.
- result_hit  out  1  1 = ship cell hit; valid only with result_valid.
- result_invalid  out  1  row out of range; valid only with result_valid.

Behaviour:
- Reset (resetGeral=0, asynchronous):
  - State = IDLE; shot_ready=1.
  - All other outputs 0: readyColisor, jogadorColisor, colisor_addr, colisor_data, both wrep, and all result signals.
  - Any in-flight write is aborted immediately; the row is left unmodified.
- States: IDLE, REQ, WAIT, CHECK, WRITE, DONE.
- IDLE:
  - shot_ready=1.
  - Accept on rising edge with shot_valid=1; latch row, col and player.
  - shot_ready drops the cycle after accept; shot inputs are ignored while busy.
  - Accepted row >= ROWS: go to DONE, result_invalid=1, result_hit=0, no bus activity. result_valid follows 1 cycle after accept.
  - Otherwise go to REQ.
- REQ:
  - readyColisor=1; colisor_addr and jogadorColisor = latched values.
  - These are held through REQ, WAIT, CHECK and WRITE.
  - Wait counter loaded with READ_LAT-1.
- WAIT: count down; exit to CHECK at 0. READ_LAT=1 passes through WAIT for a single cycle.
- CHECK:
  - Register dataReadColisor.
  - hit = row bit [col].
  - colisor_data = row with bit col cleared, i.e. AND with the inverted one-hot mask.
- WRITE:
  - On hit: exactly one cycle of colisor_wrep1 (player 0) or colisor_wrep2 (player 1). Both are never high together.
  - On miss: no enable; the cycle is still spent, so latency is uniform.
- DONE:
  - readyColisor=0; result_valid=1 for one cycle with result_hit.
  - Return to IDLE; shot_ready=1 in the following cycle.
- Latency, valid row: accept edge to result_valid = READ_LAT+4 cycles (REQ, WAIT×READ_LAT, CHECK, WRITE, DONE). Throughput: one shot per READ_LAT+5 cycles.
- Repeat shot on an already-cleared cell: reported as a miss, no write.
- col beyond DATA_W-1: cannot occur while COL_W = log2(DATA_W).
- Between shots, readyColisor stays 0, so the controller can serve other ports.

Optional Feature:
- Macro: COLISOR_CONTADOR_ACERTOS_EN.
- Enabled, adds ports:
  - acertos_p1 (out, 7): hits landed on player 1 board.
  - acertos_p2 (out, 7): hits landed on player 2 board.
- Each counter increments in the DONE cycle of a hit, saturates at 127, and resets to 0.
- Disabled: ports absent; no counter logic.

Decomposition:
- Shared package colisor_pkg:
  - state enumeration (IDLE..DONE);
  - default widths DATA_W / ADDR_W / COL_W;
  - ROWS constant;
  - player encoding constants (JOGADOR_UM=0, JOGADOR_DOIS=1), reused by the controller and validator.
- Sub-module contador_acertos: saturating 7-bit counter, instantiated twice under the macro. The FSM and datapath stay in colisor_tiro.

Test Plan:
- Reset mid-operation: assert resetGeral=0 during WRITE of a hit.
  - Required: wrep deasserts immediately, no later write occurs, shot_ready=1 after release.
  - Required: memory row unchanged; a new shot is accepted normally.
- Hit, row already cleared: player 1 row 3 = 64'h0000_0000_0000_0010; shot row=3, col=4, player=0.
  - Required: one cycle of colisor_wrep1 with colisor_data=64'h0.
  - Required: result_valid + result_hit=1 at READ_LAT+4 cycles; readyColisor and addr=3 held from REQ to WRITE.
- Hit on a full row: player 2 row 10 = all ones; shot col=63, player=1.
  - Required: colisor_wrep2 pulse, data=64'h7FFF_FFFF_FFFF_FFFF, hit=1.
  - Required: colisor_wrep1 stays 0 throughout.
- Repeat shot: same player-1 shot twice.
  - Required: second shot gives hit=0 with no wrep pulse.
  - Required: shot_valid held high across the busy window is not re-accepted.
- Invalid row: shot row=11.
  - Required: result_invalid=1, hit=0, result_valid 1 cycle after accept.
  - Required: readyColisor and both wrep remain 0.
- Back-to-back shots with COLISOR_CONTADOR_ACERTOS_EN defined: 130 hits on player 2.
  - Required: acertos_p2 saturates at 127; acertos_p1=0.
  - Required: READ_LAT=1 and READ_LAT=3 builds both pass.
